// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU core and its instruction fetch stage.
//   - Opcode constants of the core ISA (opcode = inst[15:12]).
//   - Default halt instruction word (opcode 1110 is unused by the ISA).
//   - Fetch stage state enum.
package cpu16_pkg;

  localparam logic [3:0] OP_SUM  = 4'b0000;
  localparam logic [3:0] OP_ANDI = 4'b0001;
  localparam logic [3:0] OP_ORI  = 4'b0010;
  localparam logic [3:0] OP_XORI = 4'b0011;
  localparam logic [3:0] OP_SUMI = 4'b0101;
  localparam logic [3:0] OP_SUBI = 4'b1001;
  localparam logic [3:0] OP_CMPI = 4'b1011;
  localparam logic [3:0] OP_MOVI = 4'b1101;
  localparam logic [3:0] OP_LOAD = 4'b1111;

  localparam logic [15:0] HALT_WORD_DEFAULT = 16'hE000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_mem.sv
// Program RAM for the fetch stage: one write port, one synchronous read port.
// Ports:
//   clk            - clock, all accesses on the rising edge
//   we/waddr/wdata - write port (mem[waddr] <= wdata)
//   re/raddr       - read request; rdata holds mem[raddr] one edge later
//   rdata          - registered read data (holds its value when re=0)
// Contents are never reset.
module inst_fetch_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: program RAM + PC + 2-entry output buffer feeding
// the core's inst input.
// Ports:
//   clk, rst (async, active-low)
//   start/start_pc              - leave IDLE/HALT and fetch from start_pc
//   redirect_valid/redirect_pc  - taken branch/jump in RUN: flush and refetch
//   prog_we/prog_addr/prog_wdata - program RAM write (IDLE/HALT only)
//   inst/inst_pc/inst_valid/inst_ready - instruction stream to the core
//   busy (RUN), halted (HALT), dbg_state (raw FSM state)
// Handshake: a word transfers on a rising edge where inst_valid && inst_ready;
// while inst_valid=1 and inst_ready=0, inst/inst_pc stay stable. inst_valid
// never depends on inst_ready.
// Optional build macro INST_FETCH_HALT_DETECT_EN: a fetched HALT_WORD is
// swallowed, stops issue, and the FSM enters HALT once the buffer drains.
module inst_fetch
  import cpu16_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter int          AW        = 8,
  parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_pc,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_wdata,
  output logic [15:0]   inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic          busy,
  output logic          halted,
  output fetch_state_t  dbg_state
);

  if (AW != $clog2(DEPTH)) begin : g_bad_params
    $error("inst_fetch: AW must equal log2(DEPTH)");
  end

  fetch_state_t  state, state_nx;
  logic [AW-1:0] fetch_pc;
  logic          inflight;      // a RAM read returns at the next edge
  logic [AW-1:0] inflight_pc;
  logic [15:0]   buf_word [2];  // entry 0 is the head
  logic [AW-1:0] buf_pc   [2];
  logic [1:0]    count;
  logic [15:0]   rdata;
  logic          halt_pend;

  logic       do_start, do_redirect, pop, issue, land_halt, land_keep;
  logic [2:0] occupancy;

  assign do_start    = start && (state != FETCH_RUN);
  assign do_redirect = redirect_valid && (state == FETCH_RUN);
  assign pop         = inst_valid && inst_ready;

`ifdef INST_FETCH_HALT_DETECT_EN
  assign land_halt = inflight && (rdata == HALT_WORD);
`else
  assign land_halt = 1'b0;
`endif
  assign land_keep = inflight && !land_halt;

  // Slots that will be taken after this edge if nothing new is issued.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  // A returning halt word also blocks issue in the same cycle so nothing
  // behind it is ever fetched.
  assign issue = (state == FETCH_RUN) && !do_redirect && !halt_pend &&
                 !land_halt && (occupancy < 3'd2);

  inst_fetch_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (prog_we && (state != FETCH_RUN)),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .re    (issue),
    .raddr (fetch_pc),
    .rdata (rdata)
  );

  always_comb begin
    state_nx = state;
    case (state)
      FETCH_IDLE, FETCH_HALT: if (start) state_nx = FETCH_RUN;
      FETCH_RUN: if (!do_redirect && halt_pend && (count == 2'd0)) state_nx = FETCH_HALT;
      default: state_nx = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH_IDLE;
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      buf_word[0] <= '0;
      buf_word[1] <= '0;
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
    end else begin
      state <= state_nx;
      if (do_start) begin
        fetch_pc <= start_pc;
        inflight <= 1'b0;
        count    <= 2'd0;
      end else if (do_redirect) begin
        // A same-cycle pop has already been consumed by the core; dropping
        // the whole buffer afterwards is the same as flushing after it.
        fetch_pc <= redirect_pc;
        inflight <= 1'b0;
        count    <= 2'd0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= fetch_pc + 1'b1;
        end
        if (pop) begin
          buf_word[0] <= buf_word[1];
          buf_pc[0]   <= buf_pc[1];
        end
        // The landing word goes to the first free slot after the pop; when
        // that is slot 0 it overrides the shift above.
        if (land_keep) begin
          if ((count - {1'b0, pop}) == 2'd0) begin
            buf_word[0] <= rdata;
            buf_pc[0]   <= inflight_pc;
          end else begin
            buf_word[1] <= rdata;
            buf_pc[1]   <= inflight_pc;
          end
        end
        count <= count - {1'b0, pop} + {1'b0, land_keep};
      end
    end
  end

`ifdef INST_FETCH_HALT_DETECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halt_pend <= 1'b0;
    else if (do_start || do_redirect || (state_nx == FETCH_HALT)) halt_pend <= 1'b0;
    else if (land_halt) halt_pend <= 1'b1;
  end
  assign halted = (state == FETCH_HALT);
`else
  assign halt_pend = 1'b0;
  assign halted    = 1'b0;
`endif

  assign inst_valid = (count != 2'd0);
  assign inst       = inst_valid ? buf_word[0] : '0;
  assign inst_pc    = inst_valid ? buf_pc[0] : '0;
  assign busy       = (state == FETCH_RUN);
  assign dbg_state  = state;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch. Inputs are driven and outputs sampled
// on the falling clock edge; the DUT updates on the rising edge.
// The reference is a program-memory image plus the expected PC of the next
// word the core should accept.
module tb_inst_fetch;
  import cpu16_pkg::*;

  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_pc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_wdata;
  logic [15:0]   inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic          busy;
  logic          halted;
  fetch_state_t  dbg_state;

  logic [15:0] mem_model [DEPTH];
  int vectors     = 0;
  int miscompares = 0;

  inst_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .busy(busy), .halted(halted), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic prog_write(input logic [AW-1:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    step();
    prog_we = 1'b0;
    mem_model[a] = d;
  endtask

  task automatic do_start(input logic [AW-1:0] pc);
    start = 1'b1; start_pc = pc;
    step();
    start = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'hE000) w = 16'h1E00;
    return w;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    #1;
    vectors++;
    if (inst !== 16'h0 || inst_pc !== '0 || inst_valid !== 1'b0 ||
        busy !== 1'b0 || halted !== 1'b0 || dbg_state !== FETCH_IDLE) begin
      miscompares++;
      $display("FAIL reset: inst=%h pc=%h valid=%b busy=%b halted=%b state=%0d, want all 0/IDLE",
               inst, inst_pc, inst_valid, busy, halted, dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load_stream();
    logic [15:0] words [4];
    words[0] = 16'hF10F; words[1] = 16'h0051; words[2] = 16'h5051; words[3] = 16'h9051;
    for (int i = 0; i < DEPTH; i++) prog_write(AW'(i), rand_word());
    for (int i = 0; i < 4; i++) prog_write(AW'(i), words[i]);
    inst_ready = 1'b1;
    do_start(8'h00);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL load_latency: inst_valid=%b at start+%0d, want 0", inst_valid, i + 1);
      end
      step();
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== AW'(k) || inst !== words[k]) begin
        miscompares++;
        $display("FAIL load_stream[%0d]: valid=%b pc=%h inst=%h, want 1 %h %h",
                 k, inst_valid, inst_pc, inst, AW'(k), words[k]);
      end
      step();
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b1;
    do_start(8'h00);
    step(); step();   // pc 0 shown, accepted at next edge
    step();           // pc 1 shown
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== 8'h01 || inst !== 16'h0051) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: valid=%b pc=%h inst=%h, want 1 01 0051",
                 i, inst_valid, inst_pc, inst);
      end
      step();
    end
    inst_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== AW'(k) || inst !== mem_model[k]) begin
        miscompares++;
        $display("FAIL backpressure_resume[%0d]: valid=%b pc=%h inst=%h, want 1 %h %h",
                 k, inst_valid, inst_pc, inst, AW'(k), mem_model[k]);
      end
      step();
    end
    do_reset();
  endtask

  task automatic test_redirect();
    inst_ready = 1'b1;
    do_start(8'h00);
    step(); step();   // pc 0
    step();           // pc 1
    step();           // pc 2 shown
    inst_ready = 1'b0;
    step();           // words 2,3 buffered
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 8'h02) begin
      miscompares++;
      $display("FAIL redirect_setup: valid=%b pc=%h, want 1 02", inst_valid, inst_pc);
    end
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    step();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL redirect_flush[%0d]: valid=%b pc=%h, want valid 0", i, inst_valid, inst_pc);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== AW'(8'h40 + k) || inst !== mem_model[8'h40 + k]) begin
        miscompares++;
        $display("FAIL redirect_target[%0d]: valid=%b pc=%h inst=%h, want 1 %h %h",
                 k, inst_valid, inst_pc, inst, AW'(8'h40 + k), mem_model[8'h40 + k]);
      end
      step();
    end
    do_reset();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] pc;
    inst_ready = 1'b1;
    do_start(8'hFE);
    step(); step();
    pc = 8'hFE;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== pc || inst !== mem_model[pc]) begin
        miscompares++;
        $display("FAIL wrap[%0d]: valid=%b pc=%h inst=%h, want 1 %h %h",
                 k, inst_valid, inst_pc, inst, pc, mem_model[pc]);
      end
      pc = pc + 1'b1;
      step();
    end
    do_reset();
  endtask

  task automatic test_reset_mid_run();
    inst_ready = 1'b0;
    do_start(8'h00);
    step(); step(); step();
    rst = 1'b0;
    #1;
    vectors++;
    if (inst !== 16'h0 || inst_pc !== '0 || inst_valid !== 1'b0 ||
        busy !== 1'b0 || dbg_state !== FETCH_IDLE) begin
      miscompares++;
      $display("FAIL reset_mid: inst=%h pc=%h valid=%b busy=%b state=%0d, want 0/IDLE",
               inst, inst_pc, inst_valid, busy, dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
    inst_ready = 1'b1;
    do_start(8'h00);
    step(); step();
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 8'h00 || inst !== 16'hF10F) begin
      miscompares++;
      $display("FAIL reset_restart: valid=%b pc=%h inst=%h, want 1 00 f10f", inst_valid, inst_pc, inst);
    end
    do_reset();
  endtask

  task automatic test_halt();
    logic [15:0] orig;
    orig = mem_model[2];
    prog_write(8'h02, 16'hE000);
    inst_ready = 1'b1;
    do_start(8'h00);
    step(); step();
`ifdef INST_FETCH_HALT_DETECT_EN
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== AW'(k) || inst !== mem_model[k]) begin
        miscompares++;
        $display("FAIL halt_pre[%0d]: valid=%b pc=%h inst=%h, want 1 %h %h",
                 k, inst_valid, inst_pc, inst, AW'(k), mem_model[k]);
      end
      step();
    end
    for (int n = 0; n < 10 && halted !== 1'b1; n++) begin
      vectors++;
      if (inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_word_presented: valid=%b pc=%h inst=%h, want valid 0", inst_valid, inst_pc, inst);
      end
      step();
    end
    vectors++;
    if (halted !== 1'b1 || busy !== 1'b0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_state: halted=%b busy=%b valid=%b, want 1 0 0", halted, busy, inst_valid);
    end
    prog_write(8'h02, 16'h1234);
    do_start(8'h02);
    step(); step();
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 8'h02 || inst !== 16'h1234 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_reprog: valid=%b pc=%h inst=%h halted=%b, want 1 02 1234 0",
               inst_valid, inst_pc, inst, halted);
    end
`else
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== AW'(k) || inst !== mem_model[k]) begin
        miscompares++;
        $display("FAIL halt_off[%0d]: valid=%b pc=%h inst=%h, want 1 %h %h",
                 k, inst_valid, inst_pc, inst, AW'(k), mem_model[k]);
      end
      step();
    end
    step(); step();
    vectors++;
    if (halted !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_off_state: halted=%b busy=%b, want 0 1", halted, busy);
    end
`endif
    do_reset();
    prog_write(8'h02, orig);
  endtask

  // Random ready, redirects, ignored starts and ignored program writes.
  task automatic test_random();
    logic [AW-1:0] exp_pc;
    logic          redir_now, prev_flow;
    int            accepts;
    accepts = 0;
    prev_flow = 1'b0;
    exp_pc = AW'($urandom);
    inst_ready = 1'b1;
    do_start(exp_pc);
    for (int c = 0; c < 3000; c++) begin
      if (inst_valid === 1'b1) begin
        vectors++;
        if (inst_pc !== exp_pc || inst !== mem_model[exp_pc]) begin
          miscompares++;
          $display("FAIL random_word cyc %0d: pc=%h inst=%h, want %h %h",
                   c, inst_pc, inst, exp_pc, mem_model[exp_pc]);
        end
      end
      if (prev_flow) begin
        vectors++;
        if (inst_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL random_gap cyc %0d: valid=%b, want 1", c, inst_valid);
        end
      end
      inst_ready     = ($urandom_range(0, 3) != 0);
      redir_now      = ($urandom_range(0, 19) == 0);
      redirect_valid = redir_now;
      redirect_pc    = AW'($urandom);
      start          = ($urandom_range(0, 24) == 0);
      start_pc       = AW'($urandom);
      prog_we        = ($urandom_range(0, 9) == 0);
      prog_addr      = AW'($urandom);
      prog_wdata     = 16'($urandom);
      if (inst_valid && inst_ready) begin
        exp_pc = exp_pc + 1'b1;
        accepts++;
      end
      if (redir_now) exp_pc = redirect_pc;
      prev_flow = inst_valid && inst_ready && !redir_now;
      step();
      if (redir_now) begin
        vectors++;
        if (inst_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL random_redirect cyc %0d: valid=%b, want 0", c, inst_valid);
        end
      end
    end
    redirect_valid = 1'b0; start = 1'b0; prog_we = 1'b0;
    vectors++;
    if (accepts < 1000) begin
      miscompares++;
      $display("FAIL random_progress: accepts=%0d, want >= 1000", accepts);
    end
    do_reset();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b0; start = 1'b0; start_pc = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    inst_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid_run();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Upstream instruction-supply stage for the 16-bit CPU core.
- Holds a writable program memory and a program counter.
- Streams 16-bit instruction words to the core's `inst` input over a valid/ready handshake.
- Accepts branch/jump redirects from the core, flushing any prefetched words.

Parameters:
- DEPTH, 256: program memory depth in words; power of two, ≥4.
- AW, 8: address / PC width; must equal log2(DEPTH).
- HALT_WORD, 16'hE000: instruction word treated as halt. Opcode 1110 is unused by the core's ISA.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin fetching at start_pc.
- start_pc  in  AW  initial PC, sampled with start.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  AW  redirect target address.
- prog_we  in  1  program memory write enable.
- prog_addr  in  AW  program memory write address.
- prog_wdata  in  16  program memory write data.
- inst  out  16  instruction word to core; 0 when inst_valid=0.
- inst_pc  out  AW  address of the presented inst.
- inst_valid  out  1  inst/inst_pc valid.
- inst_ready  in  1  core accepts inst this cycle.
- busy  out  1  state==RUN.
- halted  out  1  state==HALT.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; fetch_pc=0; buffer emptied; in-flight read cleared.
  - inst=0, inst_pc=0, inst_valid=0, busy=0, halted=0.
  - Memory contents are not cleared.
- States: IDLE, RUN, HALT.
  - IDLE/HALT → RUN on start; fetch_pc ← start_pc, buffer flushed.
  - RUN → HALT only via the optional feature.
  - start in RUN is ignored.
- Program writes:
  - Honoured only in IDLE/HALT; mem[prog_addr] ← prog_wdata at the edge.
  - Ignored in RUN.
- Memory read:
  - Synchronous, 1-cycle latency.
  - A read issued at edge N lands in the output buffer at edge N+1.
- Output buffer:
  - 2-entry FIFO of {word, pc}; head drives inst/inst_pc.
  - inst_valid = (count≠0).
  - Pop occurs when inst_valid && inst_ready.
- Issue rule:
  - In RUN, issue a read at fetch_pc when (count + inflight − pop) < 2; then fetch_pc ← fetch_pc+1.
  - fetch_pc wraps DEPTH−1 → 0 (modulo 2^AW, no error).
- Latency and throughput:
  - start sampled at edge S → inst_valid high after edge S+2 with inst=mem[start_pc].
  - With inst_ready held high, one instruction per cycle.
- Backpressure:
  - With inst_ready=0, inst/inst_pc are held stable while inst_valid=1.
  - No word is lost or duplicated.
  - At most 2 words buffered plus 0 in flight.
- Redirect (RUN only; ignored in IDLE/HALT):
  - At the edge: buffer flushed, in-flight read discarded, fetch_pc ← redirect_pc.
  - inst_valid=0 the following cycle; first redirected word is valid 2 cycles after the redirect edge.
- Simultaneous events:
  - Redirect with pop: the pop completes (the core consumed it), then the flush applies.
  - Redirect with start: not possible in IDLE; in RUN, start is ignored and the redirect applies.
- Reset mid-operation aborts everything immediately; no partial output survives.

Optional Feature:
- Macro: INST_FETCH_HALT_DETECT_EN.
- Enabled:
  - A read returning HALT_WORD is not enqueued and stops further issue.
  - State → HALT once the buffer drains (count=0), after which halted=1.
  - A redirect before the drain cancels the halt and continues in RUN.
- Disabled:
  - HALT_WORD is delivered as an ordinary instruction.
  - HALT is unreachable; halted tied 0.

Decomposition:
- Shared package cpu16_pkg:
  - Opcode constants (OP_SUM=4'b0000, OP_ANDI=4'b0001, OP_ORI=4'b0010, OP_XORI=4'b0011, OP_SUMI=4'b0101, OP_SUBI=4'b1001, OP_CMPI=4'b1011, OP_MOVI=4'b1101, OP_LOAD=4'b1111).
  - HALT_WORD default.
  - Fetch state enum.
- Sub-module inst_fetch_mem: single-port-write, synchronous-read program RAM.
- FSM, PC and buffer stay in inst_fetch.

Test Plan:
- Load and stream: write mem[0..3]={16'hF10F,16'h0051,16'h5051,16'h9051}, pulse start with start_pc=0, inst_ready=1 → after start edge+2, inst_valid=1 for 4 consecutive cycles with inst_pc=0,1,2,3 and matching words.
- Backpressure: inst_ready=0 for 5 cycles mid-stream at inst_pc=1 → inst=16'h0051 held stable; after release, sequence continues at pc 2 with no gap or duplicate.
- Redirect: redirect_valid with redirect_pc=8'h40 while words 2,3 are buffered → inst_valid=0 next cycle; inst_pc=8'h40 valid 2 cycles after redirect; words 2,3 never accepted.
- Wrap: start_pc=8'hFE, inst_ready=1 → inst_pc sequence FE, FF, 00, 01.
- Reset mid-run: assert rst=0 while inst_valid=1 → outputs 0 and state IDLE immediately; restart with start_pc=0 returns the original mem[0] (memory retained).
- Halt (macro on): mem[2]=16'hE000, start at 0 → pcs 0,1 delivered, HALT_WORD never presented, halted=1 after drain; prog_we accepted afterwards. With the macro off, 16'hE000 is presented at pc 2 and halted stays 0.
